// File: rtl/max7219_pkg.sv
// Shared constants and frame layout for the MAX7219-style SPI receiver.
package max7219_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [3:0] ADDR_NOOP       = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] ADDR_DECODE     = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] ADDR_TEST       = 4'hF;

    typedef struct packed {
        logic [3:0] pad;
        logic [3:0] addr;
        logic [7:0] data;
    } frame_t;

endpackage

// File: rtl/max7219_spi_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line with rise/fall detect
// against the previous synchronized value.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], i_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign o_sync = chain[SYNC_STAGES-1];
    assign o_rise = chain[SYNC_STAGES-1] & ~prev;
    assign o_fall = ~chain[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/max7219_spi_rx.sv
// Oversampling SPI responder that decodes 16-bit MAX7219 frames into a register file.
// Define MAX7219_RX_DOUT_EN to enable the 16-clock-delayed daisy-chain output on o_spi_dout.
module max7219_spi_rx
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_spi_clk,
    input  logic       i_spi_load,
    input  logic       i_spi_data,
    output logic       o_spi_dout,
    output logic       o_frame_stb,
    output logic       o_frame_err,
    output logic [3:0] o_addr,
    output logic [7:0] o_data,
    input  logic [2:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_shutdown,
    output logic       o_display_test
);

    logic clk_sync, clk_rise, clk_fall;
    logic load_sync, load_rise, load_fall;
    logic data_sync, data_rise, data_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .i_clk(i_clk), .i_rst(i_rst), .i_in(i_spi_clk),
        .o_sync(clk_sync), .o_rise(clk_rise), .o_fall(clk_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .i_clk(i_clk), .i_rst(i_rst), .i_in(i_spi_load),
        .o_sync(load_sync), .o_rise(load_rise), .o_fall(load_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .i_clk(i_clk), .i_rst(i_rst), .i_in(i_spi_data),
        .o_sync(data_sync), .o_rise(data_rise), .o_fall(data_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{clk_sync, clk_fall, data_rise, data_fall};

    logic [FRAME_BITS-1:0] sr;
    logic [4:0]            bit_cnt;
    logic [7:0]            digits [8];
    logic                  shift_en;
    frame_t                frame;
    logic [3:0]            digit_idx;

    // A clock edge seen while load is high belongs to no frame.
    assign shift_en  = clk_rise & ~load_sync;
    assign frame     = frame_t'(sr);
    assign digit_idx = frame.addr - 4'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sr             <= '0;
            bit_cnt        <= '0;
            o_frame_stb    <= 1'b0;
            o_frame_err    <= 1'b0;
            o_addr         <= '0;
            o_data         <= '0;
            o_decode_mode  <= '0;
            o_intensity    <= '0;
            o_scan_limit   <= '0;
            o_shutdown     <= 1'b1;
            o_display_test <= 1'b0;
            for (int i = 0; i < 8; i++) digits[i] <= '0;
        end else begin
            o_frame_stb <= 1'b0;
            o_frame_err <= 1'b0;

            if (shift_en)
                sr <= {sr[FRAME_BITS-2:0], data_sync};

            if (load_rise || load_fall)
                bit_cnt <= '0;
            else if (shift_en && bit_cnt != 5'd31)
                bit_cnt <= bit_cnt + 5'd1;

            if (load_rise) begin
                if (bit_cnt >= 5'(FRAME_BITS)) begin
                    o_frame_stb <= 1'b1;
                    o_addr      <= frame.addr;
                    o_data      <= frame.data;
                    case (frame.addr)
                        ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                        ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                            digits[digit_idx[2:0]] <= frame.data;
                        ADDR_DECODE:     o_decode_mode  <= frame.data;
                        ADDR_INTENSITY:  o_intensity    <= frame.data[3:0];
                        ADDR_SCAN_LIMIT: o_scan_limit   <= frame.data[2:0];
                        ADDR_SHUTDOWN:   o_shutdown     <= ~frame.data[0];
                        ADDR_TEST:       o_display_test <= frame.data[0];
                        default: ;
                    endcase
                end else begin
                    o_frame_err <= 1'b1;
                end
            end
        end
    end

    assign o_rd_data = digits[i_rd_addr];

`ifdef MAX7219_RX_DOUT_EN
    logic spi_dout;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            spi_dout <= 1'b0;
        else if (shift_en)
            spi_dout <= sr[FRAME_BITS-1];
    end

    assign o_spi_dout = spi_dout;
`else
    assign o_spi_dout = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_spi_rx.sv
// Randomized bench for max7219_spi_rx against a transaction-level register-file model.
module tb_max7219_spi_rx;

    localparam int HALF = 20;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_spi_clk = 1'b0;
    logic       i_spi_load = 1'b0;
    logic       i_spi_data = 1'b0;
    logic [2:0] i_rd_addr = 3'd0;
    logic       o_spi_dout, o_frame_stb, o_frame_err;
    logic [3:0] o_addr, o_intensity;
    logic [7:0] o_data, o_rd_data, o_decode_mode;
    logic [2:0] o_scan_limit;
    logic       o_shutdown, o_display_test;

    max7219_spi_rx #(.SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_spi_clk(i_spi_clk), .i_spi_load(i_spi_load), .i_spi_data(i_spi_data),
        .o_spi_dout(o_spi_dout), .o_frame_stb(o_frame_stb), .o_frame_err(o_frame_err),
        .o_addr(o_addr), .o_data(o_data), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_decode_mode(o_decode_mode), .o_intensity(o_intensity),
        .o_scan_limit(o_scan_limit), .o_shutdown(o_shutdown), .o_display_test(o_display_test)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // bit 16 set = error pulse expected, else a valid frame in bits 15:0
    logic [16:0] exp_q[$];

    logic [7:0] m_digit [8];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shut, m_test;
    logic [3:0] m_addr;
    logic [7:0] m_data;

    logic        dout_capture = 1'b0;
    logic [15:0] dout_bits = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = '0;
        m_decode = '0; m_int = '0; m_scan = '0; m_shut = 1'b1; m_test = 1'b0;
        m_addr = '0; m_data = '0;
        exp_q.delete();
    endfunction

    function automatic void model_apply(input logic [15:0] f);
        int a;
        a = int'(f[11:8]);
        m_addr = f[11:8];
        m_data = f[7:0];
        if (a >= 1 && a <= 8) m_digit[a-1] = f[7:0];
        else if (a == 9)  m_decode = f[7:0];
        else if (a == 10) m_int = f[3:0];
        else if (a == 11) m_scan = f[2:0];
        else if (a == 12) m_shut = ~f[0];
        else if (a == 15) m_test = f[0];
    endfunction

    // Per-cycle compare of every output against the model.
    initial begin
        logic [16:0] ev;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                if (o_frame_stb && o_frame_err)
                    check("stb_err_both", 32'd1, 32'd0);
                if (o_frame_stb || o_frame_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", {o_frame_stb, o_frame_err}, 32'd0);
                    end else begin
                        ev = exp_q.pop_front();
                        check("pulse_kind_err", 32'(o_frame_err), 32'(ev[16]));
                        if (!ev[16]) model_apply(ev[15:0]);
                    end
                end
                check("addr", 32'(o_addr), 32'(m_addr));
                check("data", 32'(o_data), 32'(m_data));
                check("rd_data", 32'(o_rd_data), 32'(m_digit[i_rd_addr]));
                check("decode_mode", 32'(o_decode_mode), 32'(m_decode));
                check("intensity", 32'(o_intensity), 32'(m_int));
                check("scan_limit", 32'(o_scan_limit), 32'(m_scan));
                check("shutdown", 32'(o_shutdown), 32'(m_shut));
                check("display_test", 32'(o_display_test), 32'(m_test));
`ifndef MAX7219_RX_DOUT_EN
                check("dout_zero", 32'(o_spi_dout), 32'd0);
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            i_rd_addr = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        model_reset();
        tick(3);
        i_rst = 1'b0;
    endtask

    // Shift the low nbits of v MSB first; optionally close the frame with a load pulse.
    task automatic spi_send(input logic [63:0] v, input int nbits, input bit do_load);
        for (int i = nbits - 1; i >= 0; i--) begin
            i_spi_data = v[i];
            tick(HALF);
            i_spi_clk = 1'b1;
            tick(HALF / 2);
            if (dout_capture) dout_bits = {dout_bits[14:0], o_spi_dout};
            tick(HALF - HALF / 2);
            i_spi_clk = 1'b0;
        end
        if (do_load) begin
            tick(HALF);
            exp_q.push_back({(nbits < 16) ? 1'b1 : 1'b0, v[15:0]});
            i_spi_load = 1'b1;
            tick(HALF);
            i_spi_load = 1'b0;
            tick(HALF);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) tick(1);
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic pin_rd(input logic [2:0] a, input logic [7:0] exp);
        @(posedge i_clk);
        #1;
        i_rd_addr = a;
        #3;
        check("pin_rd_data", 32'(o_rd_data), 32'(exp));
    endtask

    initial begin
        model_reset();
        tick(4);
        i_rst = 1'b0;
        tick(30);

        check("pin_idle_shutdown", 32'(o_shutdown), 32'd1);
        check("pin_idle_intensity", 32'(o_intensity), 32'd0);
        for (int a = 0; a < 8; a++) pin_rd(3'(a), 8'h00);

        spi_send(64'h0C01, 16, 1'b1);
        spi_send(64'h0A07, 16, 1'b1);
        drain();
        check("pin_shutdown_off", 32'(o_shutdown), 32'd0);
        check("pin_intensity_7", 32'(o_intensity), 32'd7);
        check("pin_addr_a", 32'(o_addr), 32'hA);
        check("pin_data_07", 32'(o_data), 32'h07);

        spi_send(64'h0355, 16, 1'b1);
        drain();
        pin_rd(3'd2, 8'h55);
        pin_rd(3'd1, 8'h00);
        pin_rd(3'd3, 8'h00);

        spi_send(64'h03AA, 10, 1'b1);
        drain();
        pin_rd(3'd2, 8'h55);
        check("pin_err_addr_hold", 32'(o_addr), 32'h3);

        spi_send(64'hF0F0_0301, 20, 1'b1);
        drain();
        pin_rd(3'd2, 8'h01);

        spi_send(64'h0D3C, 16, 1'b1);
        spi_send(64'h0000, 16, 1'b1);
        drain();
        check("pin_noop_intensity", 32'(o_intensity), 32'd7);

        // 40 clocks saturates the bit counter; the last 16 bits still form the frame.
        spi_send(64'hDEAD_BEEF_0942, 40, 1'b1);
        drain();
        check("pin_sat_decode", 32'(o_decode_mode), 32'h42);

        spi_send(64'h0155, 16, 1'b1);
        dout_capture = 1'b1;
        spi_send(64'h0000, 16, 1'b1);
        dout_capture = 1'b0;
        drain();
`ifdef MAX7219_RX_DOUT_EN
        check("dout_passthrough", 32'(dout_bits), 32'h0155);
`else
        check("dout_disabled", 32'(dout_bits), 32'h0000);
`endif

        for (int n = 0; n < 14; n++) begin
            logic [63:0] v;
            int nb;
            v = {$urandom, $urandom};
            nb = ($urandom_range(0, 1) == 1) ? 16 : int'($urandom_range(6, 24));
            spi_send(v, nb, 1'b1);
            drain();
        end

        // Reset in the middle of a frame drops the partial bits.
        spi_send(64'h0C00, 8, 1'b0);
        do_reset();
        tick(10);
        check("pin_reset_shutdown", 32'(o_shutdown), 32'd1);
        exp_q.push_back({1'b1, 16'h0000});
        i_spi_load = 1'b1;
        tick(HALF);
        i_spi_load = 1'b0;
        tick(HALF);
        drain();

        spi_send(64'h0B05, 16, 1'b1);
        drain();
        check("pin_scan_limit", 32'(o_scan_limit), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
